// File: rtl/ahb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ahb_mem_arbiter
// Description : Two-master AHB-Lite arbiter in front of a single AHB-Lite
//               memory slave (on-chip BRAM). Master 0 is the CPU and master 1
//               is the VGA frame-buffer fetch engine.
//
//               Each master's address phase goes into a one-entry request
//               buffer. Buffered requests are issued to the slave under
//               round-robin arbitration. A master that is not being served is
//               stalled through its own HREADY.
//
// Ports       : HCLK, HRESETn           clock, async active-low reset
//               HTRANS/HADDR/HWRITE/
//               HSIZE/HWDATA_M0/_M1     master-side request inputs
//               HREADY_M0/_M1           ready returned to each master
//               HRDATA_M0/_M1           read data returned to each master
//               HSEL_S..HWDATA_S        slave-side address/data phase
//               HREADY_S                HREADY into the slave
//               HREADYOUT_S, HRDATA_S   slave response
// Revision    : 1.0  initial release
// ============================================================================
module ahb_mem_arbiter #(
  parameter int ADDRW = 32
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  // master 0 (CPU)
  input  logic [1:0]       HTRANS_M0,
  input  logic [ADDRW-1:0] HADDR_M0,
  input  logic             HWRITE_M0,
  input  logic [2:0]       HSIZE_M0,
  input  logic [31:0]      HWDATA_M0,
  output logic             HREADY_M0,
  output logic [31:0]      HRDATA_M0,
  // master 1 (VGA fetch)
  input  logic [1:0]       HTRANS_M1,
  input  logic [ADDRW-1:0] HADDR_M1,
  input  logic             HWRITE_M1,
  input  logic [2:0]       HSIZE_M1,
  input  logic [31:0]      HWDATA_M1,
  output logic             HREADY_M1,
  output logic [31:0]      HRDATA_M1,
  // memory slave
  output logic             HSEL_S,
  output logic [1:0]       HTRANS_S,
  output logic [ADDRW-1:0] HADDR_S,
  output logic             HWRITE_S,
  output logic [2:0]       HSIZE_S,
  output logic [31:0]      HWDATA_S,
  output logic             HREADY_S,
  input  logic             HREADYOUT_S,
  input  logic [31:0]      HRDATA_S
);

  // Request buffer layout: {HADDR, HWRITE, HSIZE}
  localparam int c_BUF_W = ADDRW + 4;

  // Data-phase owner; this register is the arbiter state machine.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  owner_e             r_dp_owner;
  owner_e             w_dp_owner_nxt;
  logic               r_pend0;
  logic               r_pend1;
  logic               w_pend0_nxt;
  logic               w_pend1_nxt;
  // 0 = M0 was granted last, 1 = M1 was granted last
  logic               r_last_grant;
  logic               w_last_grant_nxt;

  logic [c_BUF_W-1:0] r_buf0;
  logic [c_BUF_W-1:0] r_buf1;
  logic [c_BUF_W-1:0] r_hold;

  logic               w_cap0;
  logic               w_cap1;
  logic               w_any_pend;
  logic               w_win_m1;
  logic               w_grant;
  logic [c_BUF_W-1:0] w_win_buf;
  logic [c_BUF_W-1:0] w_addr_bus;

  // Only bit 1 of HTRANS matters: SEQ behaves as NONSEQ, BUSY as IDLE.
  logic               w_unused;
  assign w_unused = &{1'b0, HTRANS_M0[0], HTRANS_M1[0]};

  // --------------------------------------------------------------------------
  // Master-side ready. A waiting master is always stalled; the data-phase
  // owner follows the slave; everyone else is free to start a transfer.
  // --------------------------------------------------------------------------
  always_comb begin
    HREADY_M0 = 1'b1;
    if (r_pend0) begin
      HREADY_M0 = 1'b0;
    end else if (r_dp_owner == OWN_M0) begin
      HREADY_M0 = HREADYOUT_S;
    end
  end

  always_comb begin
    HREADY_M1 = 1'b1;
    if (r_pend1) begin
      HREADY_M1 = 1'b0;
    end else if (r_dp_owner == OWN_M1) begin
      HREADY_M1 = HREADYOUT_S;
    end
  end

  assign w_cap0 = HREADY_M0 & HTRANS_M0[1];
  assign w_cap1 = HREADY_M1 & HTRANS_M1[1];

  // --------------------------------------------------------------------------
  // Arbitration. With both pending, the master that was not granted last
  // wins; otherwise the single pending master wins. The winner is computed
  // from registered state only, so the slave address phase stays stable
  // while the slave inserts wait states.
  // --------------------------------------------------------------------------
  assign w_any_pend = r_pend0 | r_pend1;
  assign w_win_m1   = (r_pend0 & r_pend1) ? ~r_last_grant : r_pend1;
  assign w_grant    = HREADYOUT_S & w_any_pend;
  assign w_win_buf  = w_win_m1 ? r_buf1 : r_buf0;
  assign w_addr_bus = w_any_pend ? w_win_buf : r_hold;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_pend0_nxt      = r_pend0;
    w_pend1_nxt      = r_pend1;
    w_last_grant_nxt = r_last_grant;
    w_dp_owner_nxt   = r_dp_owner;

    if (w_grant) begin
      w_last_grant_nxt = w_win_m1;
      if (w_win_m1) begin
        w_pend1_nxt = 1'b0;
      end else begin
        w_pend0_nxt = 1'b0;
      end
    end

    // A capture needs HREADY_Mx=1, which implies the master is not pending,
    // so it can never coincide with a grant of the same buffer.
    if (w_cap0) begin
      w_pend0_nxt = 1'b1;
    end
    if (w_cap1) begin
      w_pend1_nxt = 1'b1;
    end

    // The data phase advances only when the slave completes its beat.
    if (HREADYOUT_S) begin
      if (w_any_pend) begin
        w_dp_owner_nxt = w_win_m1 ? OWN_M1 : OWN_M0;
      end else begin
        w_dp_owner_nxt = OWN_NONE;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_pend0      <= 1'b0;
      r_pend1      <= 1'b0;
      r_last_grant <= 1'b1;
      r_dp_owner   <= OWN_NONE;
    end else begin
      r_pend0      <= w_pend0_nxt;
      r_pend1      <= w_pend1_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_dp_owner   <= w_dp_owner_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Request buffers and idle-bus hold register
  // --------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_buf0 <= '0;
      r_buf1 <= '0;
      r_hold <= '0;
    end else begin
      if (w_cap0) begin
        r_buf0 <= {HADDR_M0, HWRITE_M0, HSIZE_M0};
      end
      if (w_cap1) begin
        r_buf1 <= {HADDR_M1, HWRITE_M1, HSIZE_M1};
      end
      // Remember the last driven address phase so the bus does not toggle
      // when it goes idle.
      if (w_any_pend) begin
        r_hold <= w_win_buf;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Slave address phase
  // --------------------------------------------------------------------------
  assign HSEL_S   = w_any_pend;
  assign HTRANS_S = w_any_pend ? 2'b10 : 2'b00;
  assign HADDR_S  = w_addr_bus[c_BUF_W-1:4];
  assign HWRITE_S = w_addr_bus[3];
  assign HSIZE_S  = w_addr_bus[2:0];

  // --------------------------------------------------------------------------
  // Data phase
  // --------------------------------------------------------------------------
  always_comb begin
    HWDATA_S = 32'h0;
    case (r_dp_owner)
      OWN_M0:  HWDATA_S = HWDATA_M0;
      OWN_M1:  HWDATA_S = HWDATA_M1;
      default: HWDATA_S = 32'h0;
    endcase
  end

  assign HRDATA_M0 = HRDATA_S;
  assign HRDATA_M1 = HRDATA_S;
  assign HREADY_S  = HREADYOUT_S;

endmodule
`default_nettype wire

// File: tb/tb_ahb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_mem_arbiter
// Description : Self-checking bench for ahb_mem_arbiter with a behavioural
//               BRAM slave, a cycle-level dual-master driver and a
//               transaction-level reference memory.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ahb_mem_arbiter;

  localparam int ADDRW = 32;

  logic             HCLK = 1'b0;
  logic             HRESETn;
  logic [1:0]       HTRANS_M0, HTRANS_M1;
  logic [ADDRW-1:0] HADDR_M0, HADDR_M1;
  logic             HWRITE_M0, HWRITE_M1;
  logic [2:0]       HSIZE_M0, HSIZE_M1;
  logic [31:0]      HWDATA_M0, HWDATA_M1;
  logic             HREADY_M0, HREADY_M1;
  logic [31:0]      HRDATA_M0, HRDATA_M1;
  logic             HSEL_S;
  logic [1:0]       HTRANS_S;
  logic [ADDRW-1:0] HADDR_S;
  logic             HWRITE_S;
  logic [2:0]       HSIZE_S;
  logic [31:0]      HWDATA_S;
  logic             HREADY_S;
  logic             HREADYOUT_S;
  logic [31:0]      HRDATA_S;

  logic             slv_ready;
  int               n_checks = 0;
  int               n_pass   = 0;
  int               cyc      = 0;

  always #5 HCLK = ~HCLK;

  ahb_mem_arbiter #(.ADDRW(ADDRW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HTRANS_M0(HTRANS_M0), .HADDR_M0(HADDR_M0), .HWRITE_M0(HWRITE_M0),
    .HSIZE_M0(HSIZE_M0), .HWDATA_M0(HWDATA_M0), .HREADY_M0(HREADY_M0),
    .HRDATA_M0(HRDATA_M0),
    .HTRANS_M1(HTRANS_M1), .HADDR_M1(HADDR_M1), .HWRITE_M1(HWRITE_M1),
    .HSIZE_M1(HSIZE_M1), .HWDATA_M1(HWDATA_M1), .HREADY_M1(HREADY_M1),
    .HRDATA_M1(HRDATA_M1),
    .HSEL_S(HSEL_S), .HTRANS_S(HTRANS_S), .HADDR_S(HADDR_S),
    .HWRITE_S(HWRITE_S), .HSIZE_S(HSIZE_S), .HWDATA_S(HWDATA_S),
    .HREADY_S(HREADY_S), .HREADYOUT_S(HREADYOUT_S), .HRDATA_S(HRDATA_S)
  );

  // --------------------------------------------------------------------------
  // Shared helpers
  // --------------------------------------------------------------------------
  function automatic logic [31:0] init_word(input int idx);
    logic [31:0] v;
    v = idx;
    if (idx == 4)  return 32'hDEAD_BEEF;
    if (idx == 64) return 32'h1122_3344;
    return (v * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [3:0] lanes(input logic [31:0] a, input logic [2:0] sz);
    case (sz)
      3'd0:    return 4'b0001 << a[1:0];
      3'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Behavioural BRAM slave (zero-wait unless slv_ready is pulled low)
  // --------------------------------------------------------------------------
  logic [31:0] mem [0:1023];
  logic        s_dp_v, s_dp_wr;
  logic [31:0] s_dp_addr;
  logic [2:0]  s_dp_size;
  logic [31:0] s_log_addr[$];
  int          s_log_cyc[$];

  assign HREADYOUT_S = slv_ready;
  assign HRDATA_S    = (s_dp_v && !s_dp_wr) ? mem[s_dp_addr[11:2]] : 32'h0;

  always @(posedge HCLK) cyc <= cyc + 1;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      s_dp_v <= 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
    end else if (HREADY_S) begin
      if (s_dp_v && s_dp_wr) begin
        for (int b = 0; b < 4; b++)
          if (lanes(s_dp_addr, s_dp_size)[b]) mem[s_dp_addr[11:2]][8*b +: 8] <= HWDATA_S[8*b +: 8];
      end
      s_dp_v    <= HSEL_S & HTRANS_S[1];
      s_dp_wr   <= HWRITE_S;
      s_dp_addr <= HADDR_S;
      s_dp_size <= HSIZE_S;
      if (HSEL_S && HTRANS_S[1]) begin
        s_log_addr.push_back(HADDR_S);
        s_log_cyc.push_back(cyc);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Reference memory: each master's accesses take effect in program order
  // --------------------------------------------------------------------------
  logic [31:0] ref_mem [0:1023];

  task automatic ref_reset();
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
  endtask

  task automatic ref_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    logic [3:0] ln;
    ln = lanes(a, sz);
    for (int b = 0; b < 4; b++)
      if (ln[b]) ref_mem[a[11:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  // --------------------------------------------------------------------------
  // Master driver
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic [3:0]  gap;
  } req_t;

  req_t q0[$];
  req_t q1[$];

  task automatic drive_idle();
    HTRANS_M0 = 2'b00; HADDR_M0 = '0; HWRITE_M0 = 1'b0; HSIZE_M0 = 3'd0; HWDATA_M0 = '0;
    HTRANS_M1 = 2'b00; HADDR_M1 = '0; HWRITE_M1 = 1'b0; HSIZE_M1 = 3'd0; HWDATA_M1 = '0;
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESETn   = 1'b0;
    slv_ready = 1'b1;
    drive_idle();
    ref_reset();
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    step();
  endtask

  // Runs both request queues to completion, checking every read against the
  // data captured from the reference memory when the request was built.
  task automatic run_traffic(input int budget, input bit rand_wait);
    req_t        ap[2], dp[2];
    bit          apv[2], dpv[2];
    int          gapc[2];
    logic        hr[2];
    logic [31:0] rd[2];
    int          n;
    bit          done;
    for (int m = 0; m < 2; m++) begin
      ap[m] = '0; dp[m] = '0; apv[m] = 0; dpv[m] = 0; gapc[m] = 0;
    end
    n = 0;
    done = 0;
    while (!done && n < budget) begin
      if (!apv[0] && q0.size() > 0) begin
        if (gapc[0] < int'(q0[0].gap)) gapc[0]++;
        else begin ap[0] = q0.pop_front(); apv[0] = 1; gapc[0] = 0; end
      end
      if (!apv[1] && q1.size() > 0) begin
        if (gapc[1] < int'(q1[0].gap)) gapc[1]++;
        else begin ap[1] = q1.pop_front(); apv[1] = 1; gapc[1] = 0; end
      end
      HTRANS_M0 = apv[0] ? 2'b10 : 2'b00;
      HADDR_M0  = ap[0].addr; HWRITE_M0 = ap[0].wr; HSIZE_M0 = ap[0].size;
      HWDATA_M0 = dpv[0] ? dp[0].wdata : 32'h0;
      HTRANS_M1 = apv[1] ? 2'b10 : 2'b00;
      HADDR_M1  = ap[1].addr; HWRITE_M1 = ap[1].wr; HSIZE_M1 = ap[1].size;
      HWDATA_M1 = dpv[1] ? dp[1].wdata : 32'h0;
      slv_ready = rand_wait ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge HCLK);
      hr[0] = HREADY_M0; rd[0] = HRDATA_M0;
      hr[1] = HREADY_M1; rd[1] = HRDATA_M1;
      step();
      n++;
      for (int m = 0; m < 2; m++) begin
        if (hr[m]) begin
          if (dpv[m] && !dp[m].wr) begin
            n_checks++;
            if (rd[m] !== dp[m].exp)
              $display("FAIL read_m%0d addr=%h got=%h exp=%h", m, dp[m].addr, rd[m], dp[m].exp);
            else n_pass++;
          end
          dp[m] = ap[m]; dpv[m] = apv[m]; apv[m] = 0;
        end
      end
      done = (q0.size() == 0) && (q1.size() == 0) && !apv[0] && !apv[1] && !dpv[0] && !dpv[1];
    end
    n_checks++;
    if (!done) $display("FAIL traffic_timeout done=%0d required=1", done);
    else n_pass++;
    drive_idle();
    slv_ready = 1'b1;
  endtask

  // Builds one request in master m's region and updates the reference model.
  function automatic req_t make_req(input int m, input bit gaps);
    req_t r;
    r = '0;
    r.addr = (m == 1 ? 32'h800 : 32'h0) + ($urandom_range(0, 15) << 2);
    r.wr   = $urandom_range(0, 1);
    r.gap  = gaps ? 4'($urandom_range(0, 2)) : 4'd0;
    if (r.wr) begin
      r.size = 3'($urandom_range(0, 2));
      if (r.size == 3'd0) r.addr[1:0] = 2'($urandom_range(0, 3));
      if (r.size == 3'd1) r.addr[1]   = 1'($urandom_range(0, 1));
      r.wdata = $urandom;
    end else begin
      r.size = 3'd2;
    end
    return r;
  endfunction

  task automatic build_queues(input int cnt, input bit gaps);
    req_t r;
    q0.delete();
    q1.delete();
    for (int i = 0; i < cnt; i++) begin
      for (int m = 0; m < 2; m++) begin
        r = make_req(m, gaps);
        if (r.wr) ref_write(r.addr, r.size, r.wdata);
        else r.exp = ref_mem[r.addr[11:2]];
        if (m == 0) q0.push_back(r);
        else q1.push_back(r);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    @(negedge HCLK);
    n_checks++; if (HREADY_M0 !== 1'b1) $display("FAIL rst_hready_m0 got=%b exp=1", HREADY_M0); else n_pass++;
    n_checks++; if (HREADY_M1 !== 1'b1) $display("FAIL rst_hready_m1 got=%b exp=1", HREADY_M1); else n_pass++;
    n_checks++; if (HSEL_S !== 1'b0) $display("FAIL rst_hsel got=%b exp=0", HSEL_S); else n_pass++;
    n_checks++; if (HTRANS_S !== 2'b00) $display("FAIL rst_htrans got=%b exp=00", HTRANS_S); else n_pass++;
    n_checks++; if (HADDR_S !== 32'h0) $display("FAIL rst_haddr got=%h exp=0", HADDR_S); else n_pass++;
    n_checks++; if (HWRITE_S !== 1'b0) $display("FAIL rst_hwrite got=%b exp=0", HWRITE_S); else n_pass++;
    n_checks++; if (HSIZE_S !== 3'd0) $display("FAIL rst_hsize got=%0d exp=0", HSIZE_S); else n_pass++;
    n_checks++; if (HWDATA_S !== 32'h0) $display("FAIL rst_hwdata got=%h exp=0", HWDATA_S); else n_pass++;
    step();
  endtask

  task automatic test_single_read();
    do_reset();
    HTRANS_M0 = 2'b10; HADDR_M0 = 32'h10; HWRITE_M0 = 1'b0; HSIZE_M0 = 3'd2;
    step();
    HTRANS_M0 = 2'b00;
    @(negedge HCLK);
    n_checks++; if (HTRANS_S !== 2'b10) $display("FAIL single_htrans got=%b exp=10", HTRANS_S); else n_pass++;
    n_checks++; if (HADDR_S !== 32'h10) $display("FAIL single_haddr got=%h exp=10", HADDR_S); else n_pass++;
    n_checks++; if (HREADY_M0 !== 1'b0) $display("FAIL single_wait_m0 got=%b exp=0", HREADY_M0); else n_pass++;
    n_checks++; if (HREADY_M1 !== 1'b1) $display("FAIL single_m1_idle got=%b exp=1", HREADY_M1); else n_pass++;
    step();
    @(negedge HCLK);
    n_checks++; if (HREADY_M0 !== 1'b1) $display("FAIL single_done_m0 got=%b exp=1", HREADY_M0); else n_pass++;
    n_checks++; if (HRDATA_M0 !== 32'hDEAD_BEEF) $display("FAIL single_rdata got=%h exp=deadbeef", HRDATA_M0); else n_pass++;
    n_checks++; if (HREADY_M1 !== 1'b1) $display("FAIL single_m1_idle2 got=%b exp=1", HREADY_M1); else n_pass++;
    step();
    @(negedge HCLK);
    n_checks++; if (HSEL_S !== 1'b0) $display("FAIL single_bus_idle got=%b exp=0", HSEL_S); else n_pass++;
    step();
  endtask

  task automatic test_tie();
    int low0, low1;
    do_reset();
    low0 = 0; low1 = 0;
    HTRANS_M0 = 2'b10; HADDR_M0 = 32'h20;  HSIZE_M0 = 3'd2;
    HTRANS_M1 = 2'b10; HADDR_M1 = 32'h820; HSIZE_M1 = 3'd2;
    step();
    drive_idle();
    @(negedge HCLK);
    if (!HREADY_M0) low0++;
    if (!HREADY_M1) low1++;
    n_checks++; if (HADDR_S !== 32'h20) $display("FAIL tie_first_m0 got=%h exp=20", HADDR_S); else n_pass++;
    step();
    @(negedge HCLK);
    if (!HREADY_M0) low0++;
    if (!HREADY_M1) low1++;
    n_checks++; if (HADDR_S !== 32'h820) $display("FAIL tie_second_m1 got=%h exp=820", HADDR_S); else n_pass++;
    n_checks++; if (HRDATA_M0 !== init_word(8)) $display("FAIL tie_rdata_m0 got=%h exp=%h", HRDATA_M0, init_word(8)); else n_pass++;
    step();
    @(negedge HCLK);
    if (!HREADY_M0) low0++;
    if (!HREADY_M1) low1++;
    n_checks++; if (HRDATA_M1 !== init_word(520)) $display("FAIL tie_rdata_m1 got=%h exp=%h", HRDATA_M1, init_word(520)); else n_pass++;
    n_checks++; if (low0 != 1) $display("FAIL tie_m0_waits got=%0d exp=1", low0); else n_pass++;
    n_checks++; if (low1 != 2) $display("FAIL tie_m1_waits got=%0d exp=2", low1); else n_pass++;
    step();
  endtask

  task automatic test_fairness();
    bit alt_ok;
    int max_gap, last[2], m;
    do_reset();
    s_log_addr.delete();
    s_log_cyc.delete();
    build_queues(10, 1'b0);
    run_traffic(200, 1'b0);
    alt_ok = 1;
    max_gap = 0;
    last[0] = -1; last[1] = -1;
    for (int i = 0; i < s_log_addr.size(); i++) begin
      m = int'(s_log_addr[i][11]);
      if (i > 0 && s_log_addr[i][11] == s_log_addr[i-1][11]) alt_ok = 0;
      if (last[m] >= 0 && s_log_cyc[i] - last[m] > max_gap) max_gap = s_log_cyc[i] - last[m];
      last[m] = s_log_cyc[i];
    end
    n_checks++; if (s_log_addr.size() != 20) $display("FAIL rr_count got=%0d exp=20", s_log_addr.size()); else n_pass++;
    n_checks++; if (s_log_addr.size() > 0 && s_log_addr[0][11] !== 1'b0) $display("FAIL rr_first got=%h exp=M0 region", s_log_addr[0]); else n_pass++;
    n_checks++; if (!alt_ok) $display("FAIL rr_alternate got=0 exp=1"); else n_pass++;
    n_checks++; if (max_gap > 2) $display("FAIL rr_max_gap got=%0d exp<=2", max_gap); else n_pass++;
  endtask

  task automatic test_byte_write();
    do_reset();
    HTRANS_M1 = 2'b10; HADDR_M1 = 32'h103; HWRITE_M1 = 1'b1; HSIZE_M1 = 3'd0;
    step();
    HTRANS_M1 = 2'b00; HWRITE_M1 = 1'b0; HWDATA_M1 = 32'hA500_0000;
    @(negedge HCLK);
    n_checks++; if ({HWRITE_S, HSIZE_S, HADDR_S} !== {1'b1, 3'd0, 32'h103})
      $display("FAIL bw_addr_phase got=%b/%0d/%h exp=1/0/103", HWRITE_S, HSIZE_S, HADDR_S); else n_pass++;
    step();
    @(negedge HCLK);
    n_checks++; if (HWDATA_S !== 32'hA500_0000) $display("FAIL bw_hwdata got=%h exp=a5000000", HWDATA_S); else n_pass++;
    n_checks++; if (HREADY_M1 !== 1'b1) $display("FAIL bw_done_m1 got=%b exp=1", HREADY_M1); else n_pass++;
    step();
    HWDATA_M1 = 32'h0;
    HTRANS_M0 = 2'b10; HADDR_M0 = 32'h100; HWRITE_M0 = 1'b0; HSIZE_M0 = 3'd2;
    step();
    HTRANS_M0 = 2'b00;
    step();
    @(negedge HCLK);
    n_checks++; if (HRDATA_M0 !== 32'hA522_3344) $display("FAIL bw_readback got=%h exp=a5223344", HRDATA_M0); else n_pass++;
    step();
  endtask

  task automatic test_wait_states();
    int n_log;
    do_reset();
    HTRANS_M0 = 2'b10; HADDR_M0 = 32'h40; HWRITE_M0 = 1'b1; HSIZE_M0 = 3'd2;
    step();
    HTRANS_M0 = 2'b00; HWRITE_M0 = 1'b0; HWDATA_M0 = 32'hCAFE_0001;
    HTRANS_M1 = 2'b10; HADDR_M1 = 32'h840; HSIZE_M1 = 3'd2;
    step();
    HTRANS_M1 = 2'b00;
    slv_ready = 1'b0;
    n_log = s_log_addr.size();
    for (int k = 0; k < 3; k++) begin
      @(negedge HCLK);
      n_checks++; if (HREADY_M0 !== 1'b0) $display("FAIL ws_m0_stall%0d got=%b exp=0", k, HREADY_M0); else n_pass++;
      n_checks++; if (HWDATA_S !== 32'hCAFE_0001) $display("FAIL ws_owner%0d got=%h exp=cafe0001", k, HWDATA_S); else n_pass++;
      n_checks++; if ({HTRANS_S, HADDR_S} !== {2'b10, 32'h840}) $display("FAIL ws_m1_held%0d got=%b/%h exp=10/840", k, HTRANS_S, HADDR_S); else n_pass++;
      step();
    end
    n_checks++; if (s_log_addr.size() != n_log) $display("FAIL ws_no_grant got=%0d exp=%0d", s_log_addr.size(), n_log); else n_pass++;
    slv_ready = 1'b1;
    @(negedge HCLK);
    n_checks++; if (HREADY_M0 !== 1'b1) $display("FAIL ws_m0_release got=%b exp=1", HREADY_M0); else n_pass++;
    step();
    HWDATA_M0 = 32'h0;
    n_checks++; if (s_log_addr.size() != n_log + 1 || s_log_addr[$] !== 32'h840)
      $display("FAIL ws_m1_grant got=%0d exp=%0d", s_log_addr.size(), n_log + 1); else n_pass++;
    @(negedge HCLK);
    n_checks++; if (HRDATA_M1 !== init_word(528)) $display("FAIL ws_rdata_m1 got=%h exp=%h", HRDATA_M1, init_word(528)); else n_pass++;
    step();
    HTRANS_M0 = 2'b10; HADDR_M0 = 32'h40; HSIZE_M0 = 3'd2;
    step();
    HTRANS_M0 = 2'b00;
    step();
    @(negedge HCLK);
    n_checks++; if (HRDATA_M0 !== 32'hCAFE_0001) $display("FAIL ws_write_data got=%h exp=cafe0001", HRDATA_M0); else n_pass++;
    step();
  endtask

  task automatic test_reset_mid();
    int n_log;
    do_reset();
    HTRANS_M0 = 2'b10; HADDR_M0 = 32'h40; HSIZE_M0 = 3'd2;
    step();
    HTRANS_M0 = 2'b00;
    HTRANS_M1 = 2'b10; HADDR_M1 = 32'h840; HSIZE_M1 = 3'd2;
    step();
    HTRANS_M1 = 2'b00;
    #3;
    HRESETn = 1'b0;
    #1;
    n_checks++; if (HSEL_S !== 1'b0) $display("FAIL rm_hsel got=%b exp=0", HSEL_S); else n_pass++;
    n_checks++; if (HTRANS_S !== 2'b00) $display("FAIL rm_htrans got=%b exp=00", HTRANS_S); else n_pass++;
    n_checks++; if (HREADY_M0 !== 1'b1) $display("FAIL rm_hready_m0 got=%b exp=1", HREADY_M0); else n_pass++;
    n_checks++; if (HREADY_M1 !== 1'b1) $display("FAIL rm_hready_m1 got=%b exp=1", HREADY_M1); else n_pass++;
    n_log = s_log_addr.size();
    step();
    HRESETn = 1'b1;
    repeat (4) step();
    n_checks++; if (s_log_addr.size() != n_log) $display("FAIL rm_no_xfer got=%0d exp=%0d", s_log_addr.size(), n_log); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    build_queues(24, 1'b1);
    run_traffic(2000, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_fairness();
    test_byte_write();
    test_wait_states();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_mem_arbiter.md
# ahb_mem_arbiter

Two-master AHB-Lite arbiter that shares one AHB-Lite memory slave (the on-chip BRAM) between the CPU (master 0) and the VGA frame-buffer fetch engine (master 1). Each master's address phase is captured in a one-entry request buffer. Buffered requests are issued to the slave under round-robin arbitration, and the non-owning master is stalled through its own HREADY. The block sits between the bus matrix / VGA DMA and the memory slave port.

## Interface
- ADDRW, 32, address width on all ports
- HCLK  in  1  system clock
- HRESETn  in  1  reset; asynchronous, active-low
- HTRANS_M0 / HTRANS_M1  in  2  master transfer type
- HADDR_M0 / HADDR_M1  in  ADDRW  master address
- HWRITE_M0 / HWRITE_M1  in  1  master write flag
- HSIZE_M0 / HSIZE_M1  in  3  master transfer size
- HWDATA_M0 / HWDATA_M1  in  32  master write data, driven in the data phase
- HREADY_M0 / HREADY_M1  out  1  ready returned to each master
- HRDATA_M0 / HRDATA_M1  out  32  read data returned to each master
- HSEL_S  out  1  slave select
- HTRANS_S  out  2  slave transfer type
- HADDR_S  out  ADDRW  slave address
- HWRITE_S  out  1  slave write flag
- HSIZE_S  out  3  slave transfer size
- HWDATA_S  out  32  slave write data
- HREADY_S  out  1  HREADY into the slave
- HREADYOUT_S  in  1  slave ready
- HRDATA_S  in  32  slave read data

## Operation
- **Capture.** Master x request = HREADY_Mx & HTRANS_Mx[1] at a rising edge.
  - SEQ is treated as NONSEQ. BUSY and IDLE are ignored.
  - On capture, {HADDR, HWRITE, HSIZE} are latched into buf_x and pend_x is set.
- **Grant.** At an edge where HREADYOUT_S=1 and any pend_x=1, one buffer is granted.
  - Single pending master: that master wins.
  - Both pending: the master other than last_grant wins.
  - On grant: last_grant is updated, the granted pend is cleared, and dp_owner is set to the winner.
  - At an edge where HREADYOUT_S=1 and nothing is pending, dp_owner is set to NONE.
- **Address phase to the slave.** Driven combinationally from the buffer that wins at the next edge.
  - HSEL_S=1, HTRANS_S=2'b10, HADDR_S/HWRITE_S/HSIZE_S taken from that buffer.
  - When no buffer is pending: HSEL_S=0, HTRANS_S=2'b00, HADDR_S/HWRITE_S/HSIZE_S hold the last value.
- **Data phase.**
  - HWDATA_S = HWDATA of dp_owner (0 when NONE).
  - HRDATA_M0 = HRDATA_M1 = HRDATA_S.
  - HREADY_S = HREADYOUT_S.
- **Per-master state** (derived from pend_x and dp_owner):
  - IDLE: not pending and not owner; HREADY_Mx=1.
  - WAIT: pend_x=1; HREADY_Mx=0.
  - DATA: dp_owner=x; HREADY_Mx=HREADYOUT_S.
  - Transitions: IDLE→WAIT on capture. WAIT→DATA on grant. DATA→IDLE when HREADYOUT_S=1 with no new capture. DATA→WAIT when HREADYOUT_S=1 with a capture on the same edge.
- Pending and DATA are never both true for one master. A master is never granted while it owns the data phase.
- Byte-lane/HSIZE semantics pass through unchanged. Error responses are not supported.

## Timing
- **Reset values.** pend_0=pend_1=0, dp_owner=NONE, last_grant=M1 (so M0 wins the first tie).
  - HREADY_M0=HREADY_M1=1, HSEL_S=0, HTRANS_S=0, HADDR_S=0, HWRITE_S=0, HSIZE_S=0, HWDATA_S=0.
- **Uncontended latency** (master address phase sampled at edge E0):
  - E0→E1: slave address phase.
  - E1→E2: slave data phase.
  - HREADY_Mx=0 during E0→E1 and =1 during E1→E2 (with zero-wait memory).
  - Net: exactly one wait state; at most one transfer per master every 2 cycles.
- **Contended.** The losing master waits one extra slave transfer: two wait states with zero-wait memory.
- **Slave wait states.** HREADYOUT_S=0 freezes grant, pend bits and dp_owner. The stalled owner sees HREADY_Mx=0 and holds its HWDATA.
- **Reset mid-transfer.** Everything returns to reset values asynchronously and any in-flight transfer is dropped.

## Test plan
- **Single read.** M0 reads 0x0000_0010 (memory word 0xDEADBEEF).
  - Required: HTRANS_S=2 one cycle after the master address phase, then HRDATA_M0=0xDEADBEEF with HREADY_M0=1 exactly one cycle later; HREADY_M1 stays 1.
- **Simultaneous tie.** Both masters read at the same edge right after reset.
  - Required: M0 is granted first, M1 next cycle. HREADY_M1 is low for 2 cycles, HREADY_M0 for 1.
- **Round-robin fairness.** Both masters request continuously for 20 cycles.
  - Required: grants strictly alternate M0, M1, M0, …; neither master goes more than 2 cycles without a grant.
- **Byte write then readback.** M1 writes byte 0xA5, HSIZE=0, to 0x0000_0103.
  - Required: HWDATA_S equals M1's data during M1's data phase. A later M0 word read of 0x100 returns 0xA5 in bits [31:24] with other bytes unchanged.
- **Slave wait states.** Force HREADYOUT_S=0 for 3 cycles during M0's data phase while M1 is pending.
  - Required: dp_owner stays M0, HREADY_M0=0 for 3 cycles, M1 is not granted until HREADYOUT_S returns 1.
- **Reset mid-operation.** Assert HRESETn=0 with pend_1=1 and dp_owner=M0.
  - Required: HSEL_S=0 and HREADY_M0=HREADY_M1=1 within the reset, with no slave transfer after release.
